// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared state type and index width for the SPI bus arbiter
package spi_arb_pkg;

  // Index width sized for the largest supported requester count (8).
  localparam int NREQ_MAX = 8;
  localparam int IDX_W    = $clog2(NREQ_MAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_WAIT,
    ST_HOLD
  } arb_state_t;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// rtl/spi_arb_rr_pick.sv - round-robin pick: first set request at or after ptr, wrapping
module spi_arb_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  localparam logic [IDX_W:0] NREQ_L = (IDX_W+1)'(NREQ);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDX_W-1:0]  off;
  logic [IDX_W:0]    sum;

  // Rotating a doubled copy puts the requester at ptr into bit 0.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NREQ-1:0];
    off   = '0;
    valid = 1'b0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = IDX_W'(k);
        valid = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_L) begin
      sum = sum - NREQ_L;
    end
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - round-robin sharing of one byte-wide SPI master among NREQ requesters
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LEN_W    = 5,
  parameter int CS_GUARD = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*LEN_W-1:0] len_i,
  input  logic [NREQ*8-1:0]     tx_data_i,
  output logic [NREQ-1:0]       tx_ack_o,
  output logic [7:0]            rx_data_o,
  output logic [NREQ-1:0]       rx_valid_o,
  output logic [NREQ-1:0]       gnt_o,
  output logic                  busy_o,
  output logic [NREQ-1:0]       cs_n_o,
  output logic                  spi_start_o,
  output logic [7:0]            spi_data_o,
  input  logic [7:0]            spi_data_i,
  input  logic                  spi_fin_i
);

  localparam int               GRD_W    = (CS_GUARD > 1) ? $clog2(CS_GUARD) : 1;
  localparam logic [GRD_W-1:0] GRD_INIT = GRD_W'(CS_GUARD - 1);
  localparam logic [GRD_W-1:0] GRD_ONE  = GRD_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win;
  logic [LEN_W-1:0] byte_cnt;
  logic [GRD_W-1:0] guard_cnt;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [LEN_W-1:0] pick_len;
  logic [NREQ-1:0]  pick_onehot;
  logic [7:0]       win_tx;

  spi_arb_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req_i),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    pick_len    = '0;
    pick_onehot = '0;
    win_tx      = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (pick_idx == IDX_W'(r)) begin
        pick_len       = len_i[r*LEN_W +: LEN_W];
        pick_onehot[r] = 1'b1;
      end
      if (win == IDX_W'(r)) begin
        win_tx = tx_data_i[r*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      win         <= '0;
      byte_cnt    <= '0;
      guard_cnt   <= '0;
      gnt_o       <= '0;
      cs_n_o      <= '1;
      busy_o      <= 1'b0;
      spi_start_o <= 1'b0;
      spi_data_o  <= '0;
      tx_ack_o    <= '0;
      rx_valid_o  <= '0;
      rx_data_o   <= '0;
    end else begin
      spi_start_o <= 1'b0;
      tx_ack_o    <= '0;
      rx_valid_o  <= '0;

      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            win       <= pick_idx;
            gnt_o     <= pick_onehot;
            cs_n_o    <= ~pick_onehot;
            busy_o    <= 1'b1;
            byte_cnt  <= pick_len;
            guard_cnt <= GRD_INIT;
            // LOAD itself is the last guard cycle, so a one-cycle guard skips SETUP.
            state     <= (CS_GUARD == 1) ? ST_LOAD : ST_SETUP;
          end
        end

        ST_SETUP: begin
          guard_cnt <= guard_cnt - 1'b1;
          if (guard_cnt == GRD_ONE) begin
            state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          spi_data_o  <= win_tx;
          spi_start_o <= 1'b1;
          tx_ack_o    <= gnt_o;
          state       <= ST_WAIT;
        end

        ST_WAIT: begin
          if (spi_fin_i) begin
            rx_data_o  <= spi_data_i;
            rx_valid_o <= gnt_o;
            if (byte_cnt == '0) begin
              guard_cnt <= GRD_INIT;
              state     <= ST_HOLD;
            end else begin
              byte_cnt <= byte_cnt - 1'b1;
              state    <= ST_LOAD;
            end
          end
        end

        ST_HOLD: begin
          if (guard_cnt == '0) begin
            gnt_o  <= '0;
            cs_n_o <= '1;
            busy_o <= 1'b0;
            rr_ptr <= (win == LAST_IDX) ? '0 : win + 1'b1;
            state  <= ST_IDLE;
          end else begin
            guard_cnt <= guard_cnt - 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - randomized bench with transaction-level arbiter model
module tb_spi_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int LEN_W    = 5;
  localparam int CS_GUARD = 2;
  localparam int IW       = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  reset_i;
  logic [NREQ-1:0]       req_i;
  logic [NREQ*LEN_W-1:0] len_i;
  logic [NREQ*8-1:0]     tx_data_i;
  logic [NREQ-1:0]       tx_ack_o;
  logic [7:0]            rx_data_o;
  logic [NREQ-1:0]       rx_valid_o;
  logic [NREQ-1:0]       gnt_o;
  logic                  busy_o;
  logic [NREQ-1:0]       cs_n_o;
  logic                  spi_start_o;
  logic [7:0]            spi_data_o;
  logic [7:0]            spi_data_i;
  logic                  spi_fin_i;

  always #50 clk = ~clk;

  spi_bus_arbiter #(
    .NREQ     (NREQ),
    .LEN_W    (LEN_W),
    .CS_GUARD (CS_GUARD)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .len_i       (len_i),
    .tx_data_i   (tx_data_i),
    .tx_ack_o    (tx_ack_o),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .gnt_o       (gnt_o),
    .busy_o      (busy_o),
    .cs_n_o      (cs_n_o),
    .spi_start_o (spi_start_o),
    .spi_data_o  (spi_data_o),
    .spi_data_i  (spi_data_i),
    .spi_fin_i   (spi_fin_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: one burst at a time, tracked at transaction level.
  logic [7:0]    tx_cur [NREQ];
  int            len_v  [NREQ];
  int            ptr_m, nbytes_m, starts_m, acks_m, rxs_m;
  logic [IW-1:0] win_m;
  bit            active_m;
  logic [NREQ-1:0] gnt_prev;
  int            cyc, grant_cyc, fin_drv_cyc, rx_cyc;
  logic [7:0]    fin_byte;
  int            fin_cnt, lat_min, lat_max;
  int            last_starts, last_acks, bursts_done;
  int            gnt_log[$];
  logic [7:0]    start_log[$];
  logic [7:0]    rx_log[$];
  logic [7:0]    rx_q[$];
  logic [7:0]    tx_q[$];

  function automatic int rr_first(input logic [NREQ-1:0] r, input int p);
    logic [NREQ-1:0] m;
    for (int k = 0; k < NREQ; k++) begin
      m = NREQ'(1) << ((p + k) % NREQ);
      if ((r & m) != 0) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic pack();
    for (int r = 0; r < NREQ; r++) begin
      len_i[r*LEN_W +: LEN_W] = LEN_W'(len_v[r]);
      tx_data_i[r*8 +: 8]     = tx_cur[r];
    end
  endtask

  task automatic model_clear();
    ptr_m    = 0;
    active_m = 0;
    gnt_prev = '0;
    fin_cnt  = 0;
    starts_m = 0;
    acks_m   = 0;
    rxs_m    = 0;
    gnt_log.delete();
    start_log.delete();
    rx_log.delete();
  endtask

  task automatic step();
    logic [NREQ-1:0] req_s;
    logic [NREQ-1:0] inv_g;
    logic [NREQ-1:0] exp_g;
    int              w_exp;
    @(negedge clk);
    cyc++;
    req_s = req_i;
    inv_g = ~gnt_o;
    check("cs_vs_gnt", cs_n_o, inv_g);
    check("busy", busy_o, |gnt_o);

    if (gnt_prev == '0) begin
      w_exp = rr_first(req_s, ptr_m);
      exp_g = (w_exp < 0) ? '0 : NREQ'(1) << w_exp;
      check("grant", gnt_o, exp_g);
      if (w_exp >= 0) begin
        active_m  = 1;
        win_m     = IW'(w_exp);
        nbytes_m  = len_v[win_m] + 1;
        starts_m  = 0;
        acks_m    = 0;
        rxs_m     = 0;
        grant_cyc = cyc;
        gnt_log.push_back(w_exp);
      end
    end else if (gnt_o == '0) begin
      check("burst_starts", starts_m, nbytes_m);
      check("burst_acks", acks_m, nbytes_m);
      check("burst_rx", rxs_m, nbytes_m);
      check("cs_hold", cyc - rx_cyc, CS_GUARD);
      last_starts = starts_m;
      last_acks   = acks_m;
      bursts_done++;
      active_m    = 0;
      ptr_m       = (int'(win_m) + 1) % NREQ;
    end else begin
      check("gnt_hold", gnt_o, gnt_prev);
    end

    // SPI core model: one fin per start, lat cycles later.
    spi_fin_i = 1'b0;
    if (fin_cnt > 0) begin
      fin_cnt--;
      if (fin_cnt == 0) begin
        fin_byte    = (rx_q.size() > 0) ? rx_q.pop_front() : 8'($urandom);
        spi_data_i  = fin_byte;
        spi_fin_i   = 1'b1;
        fin_drv_cyc = cyc;
      end
    end

    if (spi_start_o) begin
      check("start_in_burst", 32'(active_m), 1);
      check("start_data", spi_data_o, tx_cur[win_m]);
      check("tx_ack", tx_ack_o, gnt_o);
      if (starts_m == 0) check("first_start_gap", cyc - grant_cyc, CS_GUARD);
      else               check("fin_to_start", cyc - fin_drv_cyc, 2);
      start_log.push_back(spi_data_o);
      starts_m++;
      fin_cnt = $urandom_range(lat_max, lat_min);
    end else begin
      check("no_ack", tx_ack_o, 0);
    end
    if (active_m && tx_ack_o[win_m]) begin
      acks_m++;
      tx_cur[win_m] = (tx_q.size() > 0) ? tx_q.pop_front() : 8'($urandom);
    end

    if (!active_m) begin
      check("rx_idle", rx_valid_o, 0);
    end else if (rx_valid_o != '0) begin
      check("rx_dst", rx_valid_o, gnt_o);
      check("rx_data", rx_data_o, fin_byte);
      rx_log.push_back(rx_data_o);
      rxs_m++;
      rx_cyc = cyc;
    end

    gnt_prev = gnt_o;
    pack();
  endtask

  task automatic do_reset();
    req_i     = '0;
    spi_fin_i = 1'b0;
    for (int r = 0; r < NREQ; r++) len_v[r] = 0;
    pack();
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    model_clear();
  endtask

  task automatic run_grants(input int n, input int max_steps);
    int k = 0;
    while (gnt_log.size() < n && k < max_steps) begin
      step();
      k++;
    end
    if (gnt_log.size() < n) check("timeout_grant", gnt_log.size(), n);
  endtask

  task automatic wait_idle(input int max_steps);
    int k = 0;
    do begin
      step();
      k++;
    end while ((gnt_o != '0 || active_m) && k < max_steps);
    if (gnt_o != '0) check("timeout_idle", gnt_o, 0);
  endtask

  function automatic int log_at(input int i);
    return (gnt_log.size() > i) ? gnt_log[i] : -1;
  endfunction

  initial begin
    reset_i    = 1'b1;
    req_i      = '0;
    spi_fin_i  = 1'b0;
    spi_data_i = '0;
    cyc        = 0;
    bursts_done = 0;
    last_starts = 0;
    last_acks   = 0;
    fin_drv_cyc = 0;
    rx_cyc      = 0;
    lat_min     = 1;
    lat_max     = 6;
    for (int r = 0; r < NREQ; r++) begin
      tx_cur[r] = '0;
      len_v[r]  = 0;
    end
    pack();
    #70;
    check("rst_cs", cs_n_o, 4'hF);
    check("rst_gnt", gnt_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_start", spi_start_o, 0);
    check("rst_ack", tx_ack_o, 0);
    check("rst_rxv", rx_valid_o, 0);
    check("rst_spi_data", spi_data_o, 0);
    check("rst_rx_data", rx_data_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    model_clear();

    // single requester, fixed 8-cycle SPI core
    lat_min = 8;
    lat_max = 8;
    tx_cur[2] = 8'hA1;
    tx_q = '{8'hA2, 8'hA3};
    rx_q = '{8'h5A, 8'h5B, 8'h5C};
    len_v[2] = 2;
    pack();
    req_i = 4'b0100;
    step();
    check("single_cs_lat", cs_n_o, 4'b1011);
    req_i = '0;
    wait_idle(400);
    check("single_starts", last_starts, 3);
    check("single_tx0", (start_log.size() > 0) ? start_log[0] : 8'h00, 8'hA1);
    check("single_tx1", (start_log.size() > 1) ? start_log[1] : 8'h00, 8'hA2);
    check("single_tx2", (start_log.size() > 2) ? start_log[2] : 8'h00, 8'hA3);
    check("single_rx0", (rx_log.size() > 0) ? rx_log[0] : 8'h00, 8'h5A);
    check("single_rx1", (rx_log.size() > 1) ? rx_log[1] : 8'h00, 8'h5B);
    check("single_rx2", (rx_log.size() > 2) ? rx_log[2] : 8'h00, 8'h5C);

    // contention, everyone requesting single bytes
    do_reset();
    lat_min = 1;
    lat_max = 6;
    req_i = '1;
    run_grants(5, 300);
    req_i = '0;
    wait_idle(200);
    for (int i = 0; i < 5; i++) check("contention_order", log_at(i), i % NREQ);

    // rotation skip: pointer sits at 1, then 3 and 0 request
    do_reset();
    len_v[0] = 1;
    pack();
    req_i = 4'b0001;
    run_grants(1, 50);
    req_i = '0;
    wait_idle(300);
    req_i = 4'b1001;
    run_grants(2, 50);
    check("rotation_skip", log_at(1), 3);
    req_i = '0;
    wait_idle(300);

    // lock: requester drops req and changes len after its first byte
    do_reset();
    len_v[1] = 3;
    pack();
    req_i = 4'b0010;
    for (int k = 0; k < 100 && !(active_m && acks_m >= 1); k++) step();
    req_i = '0;
    len_v[1] = 0;
    pack();
    wait_idle(400);
    check("lock_acks", last_acks, 4);
    check("lock_starts", last_starts, 4);

    // maximum length burst
    do_reset();
    len_v[0] = 31;
    pack();
    req_i = 4'b0001;
    run_grants(1, 50);
    req_i = '0;
    wait_idle(2000);
    check("maxlen_starts", last_starts, 32);
    check("maxlen_busy", busy_o, 0);

    // asynchronous reset while waiting on the core
    do_reset();
    lat_min = 8;
    lat_max = 8;
    len_v[3] = 4;
    pack();
    req_i = 4'b1000;
    for (int k = 0; k < 50 && starts_m == 0; k++) step();
    req_i = '0;
    step();
    step();
    #10 reset_i = 1'b1;
    #5;
    check("midrst_cs", cs_n_o, 4'hF);
    check("midrst_gnt", gnt_o, 0);
    check("midrst_busy", busy_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    model_clear();
    spi_data_i = 8'hEE;
    spi_fin_i  = 1'b1;
    step();
    check("midrst_late_fin", rx_valid_o, 0);
    step();

    // random traffic
    do_reset();
    lat_min = 1;
    lat_max = 6;
    bursts_done = 0;
    for (int k = 0; k < 4000 && bursts_done < 40; k++) begin
      step();
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(9) == 0) req_i[r] = ~req_i[r];
        if ($urandom_range(7) == 0) len_v[r] = $urandom_range(7);
      end
      pack();
    end
    check("random_bursts", 32'(bursts_done >= 40), 1);
    req_i = '0;
    wait_idle(400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
